// File: rtl/dct_job_sched.sv
// Round-robin scheduler granting one 2D DCT core to NUM_REQ requesters.
// A granted job starts one cycle after grant; it ends on core done or on timeout, then drains until core_done falls.
module dct_job_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][1:0] req_size,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_abort,
  output logic                    core_start,
  output logic [1:0]              core_size,
  input  logic                    core_done,
  output logic                    busy,
  output logic                    err_timeout,
  input  logic                    err_clear,
  output logic [15:0]             job_count
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [OW-1:0] LAST_INIT = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_last;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_abort;
  logic                r_start;
  logic [1:0]          r_size;
  logic                r_err;
  logic [15:0]         r_job_cnt;
  logic [CW-1:0]       r_cnt;

  logic                w_found;
  logic [OW-1:0]       w_pick;
  logic [OW-1:0]       w_idx;

  // First valid requester at or after last_owner+1, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = OW'((int'(r_last) + 1 + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_last    <= LAST_INIT;
      r_grant   <= '0;
      r_done    <= '0;
      r_abort   <= '0;
      r_start   <= 1'b0;
      r_size    <= 2'd0;
      r_err     <= 1'b0;
      r_job_cnt <= 16'd0;
      r_cnt     <= '0;
    end else begin
      r_done  <= '0;
      r_abort <= '0;
      // A timeout set later in this block overrides a same-cycle clear.
      if (err_clear) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_size  <= req_size[r_owner];
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            r_start   <= 1'b0;
            r_done    <= r_grant;
            r_job_cnt <= r_job_cnt + 16'd1;
            r_state   <= S_DRAIN;
          end else if (r_cnt == CNT_LAST) begin
            r_start <= 1'b0;
            r_abort <= r_grant;
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // Hold ownership until the core has returned to idle.
          if (!core_done) begin
            r_grant <= '0;
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign req_done    = r_done;
  assign req_abort   = r_abort;
  assign core_start  = r_start;
  assign core_size   = r_size;
  assign busy        = (r_state != S_IDLE);
  assign err_timeout = r_err;
  assign job_count   = r_job_cnt;

endmodule

// File: tb/tb_dct_job_sched.sv
// Directed bench for dct_job_sched with NUM_REQ=4 and a short timeout of 16 RUN cycles.
module tb_dct_job_sched;

  logic            clk;
  logic            reset;
  logic [3:0]      req_valid;
  logic [3:0][1:0] req_size;
  logic [3:0]      grant;
  logic [3:0]      req_done;
  logic [3:0]      req_abort;
  logic            core_start;
  logic [1:0]      core_size;
  logic            core_done;
  logic            busy;
  logic            err_timeout;
  logic            err_clear;
  logic [15:0]     job_count;

  int total = 0;
  int bad   = 0;
  int n_run;

  dct_job_sched #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_size    (req_size),
    .grant       (grant),
    .req_done    (req_done),
    .req_abort   (req_abort),
    .core_start  (core_start),
    .core_size   (core_size),
    .core_done   (core_done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clear   (err_clear),
    .job_count   (job_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input logic lvl);
    for (int n = 0; n < 60 && core_start !== lvl; n++) @(negedge clk);
    chk("wait_start", 32'(core_start), 32'(lvl));
  endtask

  task automatic wait_grant_nz();
    for (int n = 0; n < 60 && grant === 4'b0000; n++) @(negedge clk);
  endtask

  task automatic wait_grant_zero();
    for (int n = 0; n < 60 && grant !== 4'b0000; n++) @(negedge clk);
    chk("grant_clear", 32'(grant), 32'h0);
  endtask

  // Core model: raise done lat cycles after start is seen, hold it hold cycles after start falls.
  task automatic do_job(input int lat, input int hold);
    wait_start(1'b1);
    repeat (lat) @(negedge clk);
    core_done = 1'b1;
    wait_start(1'b0);
    repeat (hold) @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; req_valid = 4'b0; req_size = '0;
    core_done = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_start", 32'(core_start), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_jobs",  32'(job_count), 32'h0);
    chk("rst_err",   32'(err_timeout), 32'h0);
    chk("rst_size",  32'(core_size), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_grant", 32'(grant), 32'h0);

    // Round robin with all four requesting: 0,1,2,3,0.
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant_nz();
      chk("rr_grant", 32'(grant), 32'(1 << (i % 4)));
      do_job(10, 0);
      if (i == 3) chk("rr_jobs4", 32'(job_count), 32'd4);
      if (i == 4) req_valid = 4'b0;
      wait_grant_zero();
    end
    chk("rr_jobs5", 32'(job_count), 32'd5);

    // Single requester 2 with 32x32 size, cycle-exact.
    req_size[2] = 2'd3;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("a_grant", 32'(grant), 32'h4);
    chk("a_start_lo", 32'(core_start), 32'h0);
    chk("a_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("a_start_hi", 32'(core_start), 32'h1);
    chk("a_size", 32'(core_size), 32'h3);
    @(negedge clk);
    chk("a_run", 32'(core_start), 32'h1);
    core_done = 1'b1;
    @(negedge clk);
    chk("a_stop", 32'(core_start), 32'h0);
    chk("a_done", 32'(req_done), 32'h4);
    chk("a_jobs", 32'(job_count), 32'd6);
    chk("a_hold", 32'(grant), 32'h4);
    core_done = 1'b0; req_valid = 4'b0;
    @(negedge clk);
    chk("a_pulse", 32'(req_done), 32'h0);
    chk("a_rel", 32'(grant), 32'h0);
    chk("a_idle", 32'(busy), 32'h0);

    // core_done held 5 cycles after start falls; then back-to-back regrant of requester 0.
    req_valid = 4'b0001;
    @(negedge clk);
    chk("d_grant", 32'(grant), 32'h1);
    @(negedge clk);
    chk("d_start", 32'(core_start), 32'h1);
    core_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("d_nostart", 32'(core_start), 32'h0);
      chk("d_hold", 32'(grant), 32'h1);
      chk("d_busy", 32'(busy), 32'h1);
    end
    core_done = 1'b0;
    @(negedge clk);
    chk("d_rel", 32'(grant), 32'h0);
    chk("d_jobs", 32'(job_count), 32'd7);
    @(negedge clk);
    chk("d_regrant", 32'(grant), 32'h1);
    req_valid = 4'b0;
    do_job(1, 0);
    wait_grant_zero();
    chk("d_jobs2", 32'(job_count), 32'd8);

    // Timeout on requester 1: core never answers.
    req_valid = 4'b0010;
    wait_start(1'b1);
    n_run = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (core_start !== 1'b1) break;
      n_run++;
    end
    chk("to_len", 32'(n_run), 32'd16);
    chk("to_abort", 32'(req_abort), 32'h2);
    chk("to_nodone", 32'(req_done), 32'h0);
    chk("to_err", 32'(err_timeout), 32'h1);
    chk("to_jobs", 32'(job_count), 32'd8);
    chk("to_grant", 32'(grant), 32'h2);
    req_valid = 4'b0;
    @(negedge clk);
    chk("to_pulse", 32'(req_abort), 32'h0);
    chk("to_sticky", 32'(err_timeout), 32'h1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("to_clr", 32'(err_timeout), 32'h0);

    // Timeout while err_clear is held: set wins on the abort edge.
    err_clear = 1'b1;
    req_valid = 4'b1000;
    for (int n = 0; n < 40 && req_abort === 4'b0000; n++) @(negedge clk);
    chk("sw_abort", 32'(req_abort), 32'h8);
    chk("sw_err", 32'(err_timeout), 32'h1);
    req_valid = 4'b0;
    @(negedge clk);
    chk("sw_clr", 32'(err_timeout), 32'h0);
    err_clear = 1'b0;
    wait_grant_zero();

    // core_done arriving on the timeout cycle counts as completion.
    req_valid = 4'b0001;
    wait_start(1'b1);
    repeat (15) @(negedge clk);
    chk("tie_start", 32'(core_start), 32'h1);
    core_done = 1'b1;
    @(negedge clk);
    chk("tie_done", 32'(req_done), 32'h1);
    chk("tie_abort", 32'(req_abort), 32'h0);
    chk("tie_jobs", 32'(job_count), 32'd9);
    chk("tie_err", 32'(err_timeout), 32'h0);
    core_done = 1'b0; req_valid = 4'b0;
    wait_grant_zero();

    // job_count wrap from a preloaded value.
    force dut.r_job_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_job_cnt;
    req_valid = 4'b0010;
    do_job(0, 0);
    chk("wrap_ffff", 32'(job_count), 32'hFFFF);
    do_job(0, 0);
    chk("wrap_zero", 32'(job_count), 32'h0);
    req_valid = 4'b0;
    wait_grant_zero();

    // Reset in the middle of RUN.
    req_valid = 4'b0100;
    wait_start(1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_start", 32'(core_start), 32'h0);
    chk("mr_size", 32'(core_size), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_jobs", 32'(job_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("mr_regrant", 32'(grant), 32'h1);
    do_job(1, 0);
    req_valid = 4'b0;
    wait_grant_zero();
    chk("mr_jobs1", 32'(job_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
